wb_ram_slave: RTL and testbench
===============================

// Module: wb_ram_slave
// PURPOSE
//  Wishbone B4 classic single-port RAM slave on one slave port of the multiplexed interconnect.
//  Consumes the interconnect's per-slave stb and its shared cyc/adr/dat/sel/we.
//  Returns ack/err/dat after a parameterised number of wait states.
//  Serves as the default memory target and as the timing/abort stimulus for interconnect benches.
// PARAMETERS
//  ADDR_WIDTH   12  width of byte address seen by slave (interconnect strips upper 4 bits)
//  DATA_WIDTH   32  data bus width; multiple of 8
//  DEPTH        256 number of DATA_WIDTH words; power of two; DEPTH*DATA_WIDTH/8 <= 2**ADDR_WIDTH
//  WAIT_STATES  0   extra cycles between request accept and ack; 0..15
//  (local) SEL_WIDTH = DATA_WIDTH/8; IDX_LSB = $clog2(SEL_WIDTH); IDX_W = $clog2(DEPTH)
// PORTS
//  clk_i    in   1           clock; all logic on rising edge
//  rst_i    in   1           reset, synchronous, active-low
//  cyc_i    in   1           bus cycle in progress
//  stb_i    in   1           strobe, this slave selected
//  we_i     in   1           1 = write, 0 = read
//  adr_i    in   ADDR_WIDTH  byte address
//  dat_i    in   DATA_WIDTH  write data
//  sel_i    in   SEL_WIDTH   byte-lane enables, bit n -> dat[8n+7:8n]
//  ack_o    out  1           transfer complete, one-cycle pulse
//  err_o    out  1           transfer error, one-cycle pulse (only with WB_RAM_ERR_EN)
//  dat_o    out  DATA_WIDTH  read data, valid in ack cycle
// BEHAVIOUR
//  Reset (rst_i==0 at a clock edge): state=IDLE, wait counter=0, ack_o=0, err_o=0, dat_o=0. RAM contents not cleared.
//  Reset mid-transfer: transfer dropped, no ack/err, no write.
//  Request = cyc_i & stb_i. Word index = adr_i[IDX_LSB +: IDX_W].
//  Address bits below IDX_LSB are ignored.
//  FSM:
//   IDLE: on request, latch we/adr/dat/sel, cnt<=WAIT_STATES.
//         If WAIT_STATES==0 go RESP, else go WAIT.
//   WAIT: if !cyc_i | !stb_i -> IDLE (abort: no write, no ack); elif cnt==1 -> RESP; else cnt<=cnt-1.
//   RESP: ack_o (or err_o) high this cycle only.
//         Write committed on the edge entering RESP, per set sel bit; lanes with sel=0 unchanged.
//         Read: dat_o loaded on the edge entering RESP with the word's value; held until the next read completes.
//         Writes leave dat_o unchanged.
//         Next state always IDLE.
//  Latency: request sampled at edge N -> ack_o high during cycle N+1+WAIT_STATES.
//  Throughput: one transfer per 2+WAIT_STATES cycles. Request still high in IDLE after RESP = new transfer.
//  Request inputs are sampled only in IDLE.
//  Changes on adr/dat/sel/we during WAIT are ignored (latched copy used).
//  ack_o and err_o are registered outputs, never both high, never high outside RESP.
//  Master dropping cyc_i in the RESP cycle: ack still pulses, write still committed.
//  sel_i==0 write: acked, no RAM change.
// CONFIGURATION
//  WB_RAM_ERR_EN defined:
//   - A request with adr_i >= DEPTH*SEL_WIDTH takes the same latency but pulses err_o instead of ack_o.
//   - No write occurs; dat_o is unchanged.
//  WB_RAM_ERR_EN undefined:
//   - err_o tied 0.
//   - Out-of-range addresses alias modulo DEPTH words and are acked normally.
// TESTING
//  T1 WAIT_STATES=0: write 0xDEADBEEF @0x010, sel=0xF, then read @0x010 -> ack 1 cycle after each accept, dat_o=0xDEADBEEF.
//  T2 byte lanes: word @0x020 = 0x11223344; write 0xAABBCCDD sel=0x5 -> read returns 0x11BB33DD.
//  T3 WAIT_STATES=3: read request held -> ack_o first high exactly 4 cycles after accept edge; pulse width 1 cycle.
//  T4 abort: WAIT_STATES=3, write 0x5 @0x040, drop stb after 1 wait cycle -> no ack; read @0x040 returns old value.
//  T5 WB_RAM_ERR_EN, DEPTH=256: read @0x400 -> err_o=1, ack_o=0; same stimulus with macro undefined -> ack_o=1, data of word 0.
//  T6 reset: rst_i=0 during WAIT -> ack_o=err_o=dat_o=0 next cycle; FSM in IDLE; RAM write not performed.

Source files
------------

// File: rtl/wb_ram_slave.sv
// Wishbone B4 classic single-port RAM slave, ack after WAIT_STATES extra cycles.
// Define WB_RAM_ERR_EN to answer out-of-range addresses with err_o instead of aliasing them.
module wb_ram_slave #(
  parameter int ADDR_WIDTH  = 12,
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    cyc_i,
  input  logic                    stb_i,
  input  logic                    we_i,
  input  logic [ADDR_WIDTH-1:0]   adr_i,
  input  logic [DATA_WIDTH-1:0]   dat_i,
  input  logic [DATA_WIDTH/8-1:0] sel_i,
  output logic                    ack_o,
  output logic                    err_o,
  output logic [DATA_WIDTH-1:0]   dat_o
);
  localparam int SEL_WIDTH = DATA_WIDTH / 8;
  localparam int IDX_LSB   = $clog2(SEL_WIDTH);
  localparam int IDX_W     = $clog2(DEPTH);
  localparam logic [3:0] WS = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t                state_r, state_nx;
  logic [3:0]            cnt_r, cnt_nx;
  logic                  we_r, oor_r;
  logic [IDX_W-1:0]      idx_r;
  logic [DATA_WIDTH-1:0] wdat_r;
  logic [SEL_WIDTH-1:0]  sel_r;

  logic                  req_s, take_s, go_resp_s, in_idle_s;
  logic                  oor_in_s, we_eff_s, oor_eff_s, wr_en_s, rd_en_s;
  logic [IDX_W-1:0]      idx_eff_s;
  logic [DATA_WIDTH-1:0] wdat_eff_s;
  logic [SEL_WIDTH-1:0]  sel_eff_s;
  logic                  unused_adr;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  assign req_s      = cyc_i & stb_i;
  assign unused_adr = ^adr_i;

`ifdef WB_RAM_ERR_EN
  localparam logic [ADDR_WIDTH:0] ADR_LIMIT = (ADDR_WIDTH+1)'(DEPTH * SEL_WIDTH);
  assign oor_in_s = ({1'b0, adr_i} >= ADR_LIMIT);
`else
  assign oor_in_s = 1'b0;
`endif

  // With no wait states the response edge is the accept edge, so live inputs are used there.
  assign in_idle_s  = (state_r == ST_IDLE);
  assign we_eff_s   = in_idle_s ? we_i : we_r;
  assign oor_eff_s  = in_idle_s ? oor_in_s : oor_r;
  assign idx_eff_s  = in_idle_s ? adr_i[IDX_LSB +: IDX_W] : idx_r;
  assign wdat_eff_s = in_idle_s ? dat_i : wdat_r;
  assign sel_eff_s  = in_idle_s ? sel_i : sel_r;
  assign wr_en_s    = go_resp_s & we_eff_s & ~oor_eff_s;
  assign rd_en_s    = go_resp_s & ~we_eff_s & ~oor_eff_s;

  always_comb begin
    state_nx  = state_r;
    cnt_nx    = cnt_r;
    take_s    = 1'b0;
    go_resp_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (req_s) begin
          take_s = 1'b1;
          cnt_nx = WS;
          if (WS == 4'd0) begin
            state_nx  = ST_RESP;
            go_resp_s = 1'b1;
          end else begin
            state_nx = ST_WAIT;
          end
        end else begin
          state_nx = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (!req_s) begin
          state_nx = ST_IDLE;
        end else if (cnt_r == 4'd1) begin
          state_nx  = ST_RESP;
          go_resp_s = 1'b1;
        end else begin
          cnt_nx = cnt_r - 4'd1;
        end
      end
      ST_RESP: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_r <= ST_IDLE;
      cnt_r   <= 4'd0;
      ack_o   <= 1'b0;
      dat_o   <= '0;
      we_r    <= 1'b0;
      oor_r   <= 1'b0;
      idx_r   <= '0;
      wdat_r  <= '0;
      sel_r   <= '0;
    end else begin
      state_r <= state_nx;
      cnt_r   <= cnt_nx;
      ack_o   <= go_resp_s & ~oor_eff_s;
      if (rd_en_s) begin
        dat_o <= mem[idx_eff_s];
      end
      if (take_s) begin
        we_r   <= we_i;
        oor_r  <= oor_in_s;
        idx_r  <= adr_i[IDX_LSB +: IDX_W];
        wdat_r <= dat_i;
        sel_r  <= sel_i;
      end
    end
  end

`ifdef WB_RAM_ERR_EN
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      err_o <= 1'b0;
    end else begin
      err_o <= go_resp_s & oor_eff_s;
    end
  end
`else
  assign err_o = 1'b0;
`endif

  // Storage is not reset; a reset edge also suppresses a write that would land on it.
  always_ff @(posedge clk_i) begin
    if (rst_i && wr_en_s) begin
      for (int b = 0; b < SEL_WIDTH; b++) begin
        if (sel_eff_s[b]) begin
          mem[idx_eff_s][8*b +: 8] <= wdat_eff_s[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_wb_ram_slave.sv
// Bench for wb_ram_slave: dut0 has no wait states, dut1 has three; both checked every cycle
// against a transaction-timeline model, plus literal expectations for the directed tests.
module tb_wb_ram_slave;
`ifdef WB_RAM_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  cyc = 2'b00;
  logic [1:0]  stb = 2'b00;
  logic [1:0]  we  = 2'b00;
  logic [11:0] adr  [2] = '{12'h000, 12'h000};
  logic [31:0] wdat [2] = '{32'h0, 32'h0};
  logic [3:0]  sel  [2] = '{4'h0, 4'h0};
  logic [1:0]  ack, err;
  logic [31:0] rdat [2];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  wb_ram_slave #(.WAIT_STATES(0)) dut0 (
    .clk_i(clk), .rst_i(rst), .cyc_i(cyc[0]), .stb_i(stb[0]), .we_i(we[0]),
    .adr_i(adr[0]), .dat_i(wdat[0]), .sel_i(sel[0]),
    .ack_o(ack[0]), .err_o(err[0]), .dat_o(rdat[0])
  );

  wb_ram_slave #(.WAIT_STATES(3)) dut1 (
    .clk_i(clk), .rst_i(rst), .cyc_i(cyc[1]), .stb_i(stb[1]), .we_i(we[1]),
    .adr_i(adr[1]), .dat_i(wdat[1]), .sel_i(sel[1]),
    .ack_o(ack[1]), .err_o(err[1]), .dat_o(rdat[1])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: a transfer accepted at edge a answers at edge a+WS if the request stays up on
  // every edge in between; the next accept is possible two edges after the answer.
  int          edge_n = 0;
  int          acc_e  [2] = '{0, 0};
  int          free_e [2] = '{0, 0};
  bit          pend   [2] = '{1'b0, 1'b0};
  bit          seen_rst = 1'b0;
  logic        m_we  [2];
  logic [11:0] m_adr [2];
  logic [31:0] m_dat [2];
  logic [3:0]  m_sel [2];
  logic [31:0] mem   [2][256];
  logic [1:0]  exp_ack = 2'b00;
  logic [1:0]  exp_err = 2'b00;
  logic [31:0] exp_dat [2] = '{32'h0, 32'h0};

  function automatic int ws(input int d);
    return (d == 0) ? 0 : 3;
  endfunction

  task automatic model_respond(input int d);
    int idx;
    bit oor;
    pend[d]   = 1'b0;
    free_e[d] = edge_n + 2;
    idx = (int'(m_adr[d]) / 4) % 256;
    oor = ERR_EN && (m_adr[d] >= 12'h400);
    if (oor) begin
      exp_err[d] = 1'b1;
    end else begin
      exp_ack[d] = 1'b1;
      if (m_we[d]) begin
        for (int b = 0; b < 4; b++) begin
          if (m_sel[d][b]) mem[d][idx][8*b +: 8] = m_dat[d][8*b +: 8];
        end
      end else begin
        exp_dat[d] = mem[d][idx];
      end
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      edge_n++;
      for (int d = 0; d < 2; d++) begin
        exp_ack[d] = 1'b0;
        exp_err[d] = 1'b0;
        if (!rst) begin
          seen_rst   = 1'b1;
          pend[d]    = 1'b0;
          exp_dat[d] = 32'h0;
          free_e[d]  = edge_n + 1;
        end else if (pend[d]) begin
          if (!(cyc[d] && stb[d])) begin
            pend[d]   = 1'b0;
            free_e[d] = edge_n + 1;
          end else if (edge_n == acc_e[d] + ws(d)) begin
            model_respond(d);
          end
        end else if (edge_n >= free_e[d] && cyc[d] && stb[d]) begin
          m_we[d]  = we[d];
          m_adr[d] = adr[d];
          m_dat[d] = wdat[d];
          m_sel[d] = sel[d];
          acc_e[d] = edge_n;
          pend[d]  = 1'b1;
          if (ws(d) == 0) model_respond(d);
        end
      end
      @(negedge clk);
      if (seen_rst) begin
        for (int d = 0; d < 2; d++) begin
          chk($sformatf("cyc_ack%0d", d), ack[d], exp_ack[d]);
          chk($sformatf("cyc_err%0d", d), err[d], exp_err[d]);
          chk($sformatf("cyc_dat%0d", d), rdat[d], exp_dat[d]);
        end
      end
    end
  end

  // lat counts clock edges from raising the request to the edge after which ack/err is seen.
  task automatic xfer(input int d, input logic w, input logic [11:0] a, input logic [31:0] dd,
                      input logic [3:0] s, input bit hold, output int lat, output logic ge);
    bit done;
    @(negedge clk);
    cyc[d] = 1'b1; stb[d] = 1'b1; we[d] = w; adr[d] = a; wdat[d] = dd; sel[d] = s;
    lat = 0; ge = 1'b0; done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      lat++;
      if (ack[d] || err[d]) begin
        done = 1'b1;
        ge   = err[d];
      end
    end
    chk($sformatf("xfer_done%0d", d), 32'(done), 32'd1);
    if (hold) begin
      @(negedge clk);
      chk("t3_pulse_width", ack[d], 1'b0);
    end
    cyc[d] = 1'b0; stb[d] = 1'b0;
  endtask

  initial begin
    int   lat;
    logic ge;
    bit   seen;
    repeat (3) @(negedge clk);
    rst = 1'b1;

    // T1: zero wait states
    xfer(0, 1'b1, 12'h010, 32'hDEADBEEF, 4'hF, 1'b0, lat, ge);
    chk("t1_wr_lat", lat, 1);
    xfer(0, 1'b0, 12'h010, 32'h0, 4'hF, 1'b0, lat, ge);
    chk("t1_rd_lat", lat, 1);
    chk("t1_rd_dat", rdat[0], 32'hDEADBEEF);

    // T2: byte lanes, empty sel, ignored low address bits
    xfer(0, 1'b1, 12'h020, 32'h11223344, 4'hF, 1'b0, lat, ge);
    xfer(0, 1'b1, 12'h020, 32'hAABBCCDD, 4'h5, 1'b0, lat, ge);
    xfer(0, 1'b0, 12'h020, 32'h0, 4'hF, 1'b0, lat, ge);
    chk("t2_lanes", rdat[0], 32'h11BB33DD);
    xfer(0, 1'b1, 12'h020, 32'hFFFFFFFF, 4'h0, 1'b0, lat, ge);
    chk("t2_sel0_ack", 32'(ge), 32'd0);
    xfer(0, 1'b0, 12'h023, 32'h0, 4'hF, 1'b0, lat, ge);
    chk("t2_sel0_dat", rdat[0], 32'h11BB33DD);

    // T3: three wait states, pulse width with request still held
    xfer(1, 1'b1, 12'h010, 32'h0BADF00D, 4'hF, 1'b0, lat, ge);
    chk("t3_wr_lat", lat, 4);
    xfer(1, 1'b0, 12'h010, 32'h0, 4'hF, 1'b1, lat, ge);
    chk("t3_rd_lat", lat, 4);
    chk("t3_rd_dat", rdat[1], 32'h0BADF00D);

    // T4: abort after one wait cycle
    xfer(1, 1'b1, 12'h040, 32'h12345678, 4'hF, 1'b0, lat, ge);
    @(negedge clk);
    cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1; adr[1] = 12'h040; wdat[1] = 32'h5; sel[1] = 4'hF;
    @(negedge clk);
    @(negedge clk);
    stb[1] = 1'b0; cyc[1] = 1'b0;
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (ack[1] || err[1]) seen = 1'b1;
    end
    chk("t4_no_ack", 32'(seen), 32'd0);
    xfer(1, 1'b0, 12'h040, 32'h0, 4'hF, 1'b0, lat, ge);
    chk("t4_old_dat", rdat[1], 32'h12345678);

    // T5: out-of-range address
    xfer(0, 1'b1, 12'h000, 32'hCAFEF00D, 4'hF, 1'b0, lat, ge);
    xfer(0, 1'b0, 12'h400, 32'h0, 4'hF, 1'b0, lat, ge);
    chk("t5_lat", lat, 1);
`ifdef WB_RAM_ERR_EN
    chk("t5_err", 32'(ge), 32'd1);
    chk("t5_ack", ack[0], 1'b0);
    chk("t5_dat_kept", rdat[0], 32'h11BB33DD);
`else
    chk("t5_err", 32'(ge), 32'd0);
    chk("t5_ack", ack[0], 1'b1);
    chk("t5_alias_dat", rdat[0], 32'hCAFEF00D);
`endif

    // T6: reset during WAIT
    xfer(1, 1'b1, 12'h080, 32'hA5A5A5A5, 4'hF, 1'b0, lat, ge);
    @(negedge clk);
    cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1; adr[1] = 12'h080; wdat[1] = 32'h77; sel[1] = 4'hF;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("t6_ack", ack[1], 1'b0);
    chk("t6_err", err[1], 1'b0);
    chk("t6_dat", rdat[1], 32'h0);
    cyc[1] = 1'b0; stb[1] = 1'b0;
    rst = 1'b1;
    xfer(1, 1'b0, 12'h080, 32'h0, 4'hF, 1'b0, lat, ge);
    chk("t6_no_write", rdat[1], 32'hA5A5A5A5);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
